// File: rtl/predictor_port_scheduler_if.sv
// Bundle of the lookup, resolve and predictor-side signals around the port scheduler.
// The scheduler takes the slave view; the environment that drives IF, ROB and the predictor takes the master view.
interface predictor_port_scheduler_if #(
    parameter int LOCAL_WIDTH = 10,
    parameter int QUEUE_DEPTH = 4
);
    logic                           rdy_in;
    logic                           lookup_valid;
    logic [31:0]                    lookup_addr;
    logic                           lookup_grant;
    logic                           pred_valid;
    logic                           pred_taken;
    logic                           resolve_valid;
    logic [31:0]                    resolve_addr;
    logic                           resolve_correct;
    logic                           resolve_ready;
    logic [$clog2(QUEUE_DEPTH):0]   queue_count;
    logic [LOCAL_WIDTH-1:0]         pd_addr;
    logic                           pd_transition;
    logic                           pd_correctness;
    logic                           pd_prediction;

    modport slave (
        input  rdy_in, lookup_valid, lookup_addr,
        input  resolve_valid, resolve_addr, resolve_correct,
        input  pd_prediction,
        output lookup_grant, pred_valid, pred_taken,
        output resolve_ready, queue_count,
        output pd_addr, pd_transition, pd_correctness
    );

    modport master (
        output rdy_in, lookup_valid, lookup_addr,
        output resolve_valid, resolve_addr, resolve_correct,
        output pd_prediction,
        input  lookup_grant, pred_valid, pred_taken,
        input  resolve_ready, queue_count,
        input  pd_addr, pd_transition, pd_correctness
    );
endinterface

// File: rtl/predictor_port_scheduler.sv
// Shares the predictor's single address/update port between fetch lookups and
// replayed resolved-branch updates (address in one cycle, transition pulse the next).
module predictor_port_scheduler #(
    parameter int LOCAL_WIDTH  = 10,
    parameter int QUEUE_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic                        clk_in,
    input logic                        rst_in,
    predictor_port_scheduler_if.slave  bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [7:0]       STARVE_MAX = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_LOOKUP,
        SLOT_UPDATE
    } slot_e;

    logic [LOCAL_WIDTH-1:0] mem_idx [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] mem_corr;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       starve_q, starve_d;
    logic             upd_q, upd_d;
    logic             corr_q, corr_d;
    logic             lkp_q, lkp_d;

    slot_e slot;
    logic  nonempty;
    logic  full;
    logic  push;
    logic  pop;
    logic  unused_addr_bits;

    assign nonempty = (count_q != '0);
    assign full     = (count_q == FULL_COUNT);

    // Forced updates (queue full or lookups have starved the queue) outrank fetch.
    always_comb begin
        slot = SLOT_NONE;
        if (!bus.rdy_in) begin
            slot = SLOT_NONE;
        end else if (nonempty && (full || starve_q == STARVE_MAX)) begin
            slot = SLOT_UPDATE;
        end else if (bus.lookup_valid) begin
            slot = SLOT_LOOKUP;
        end else if (nonempty) begin
            slot = SLOT_UPDATE;
        end
    end

    assign push = bus.rdy_in & bus.resolve_valid & ~full;
    assign pop  = (slot == SLOT_UPDATE);

    assign bus.resolve_ready  = bus.rdy_in & ~full;
    assign bus.lookup_grant   = (slot == SLOT_LOOKUP);
    assign bus.queue_count    = count_q;
    assign bus.pd_addr        = pop ? mem_idx[rd_ptr_q] : bus.lookup_addr[LOCAL_WIDTH+1:2];
    assign bus.pd_transition  = upd_q & bus.rdy_in;
    assign bus.pd_correctness = corr_q;
    assign bus.pred_valid     = lkp_q & bus.rdy_in;
    assign bus.pred_taken     = bus.pred_valid & bus.pd_prediction;

    assign unused_addr_bits = ^{bus.lookup_addr[31:LOCAL_WIDTH+2], bus.lookup_addr[1:0],
                                bus.resolve_addr[31:LOCAL_WIDTH+2], bus.resolve_addr[1:0]};

    // Next-state for FIFO bookkeeping, starvation counter and the one-cycle stage registers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        upd_d    = upd_q;
        corr_d   = corr_q;
        lkp_d    = lkp_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (bus.rdy_in) begin
            upd_d  = pop;
            corr_d = pop & mem_corr[rd_ptr_q];
            lkp_d  = (slot == SLOT_LOOKUP);
            if (pop || !nonempty) begin
                starve_d = '0;
            end else if (slot == SLOT_LOOKUP && starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Queue storage needs no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_idx[wr_ptr_q]  <= bus.resolve_addr[LOCAL_WIDTH+1:2];
            mem_corr[wr_ptr_q] <= bus.resolve_correct;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            upd_q    <= 1'b0;
            corr_q   <= 1'b0;
            lkp_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            upd_q    <= upd_d;
            corr_q   <= corr_d;
            lkp_q    <= lkp_d;
        end
    end
endmodule

// File: tb/tb_predictor_port_scheduler.sv
// Directed bench for predictor_port_scheduler: a cycle-by-cycle vector table plus
// hand-written sequences for starvation, full queue, ready stalls and reset mid-update.
module tb_predictor_port_scheduler;
    localparam int LW = 10;
    localparam int QD = 4;
    localparam int SL = 8;

    typedef struct {
        logic        rdy;
        logic        lv;
        logic [31:0] la;
        logic        rv;
        logic [31:0] ra;
        logic        rc;
        logic        pp;
        logic        grant;
        logic [9:0]  pda;
        logic        pv;
        logic        pt;
        logic        tr;
        logic        co;
        logic        rr;
        logic [2:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertCount = 0;
    int   failCount = 0;
    vec_t vecs [14];

    predictor_port_scheduler_if #(.LOCAL_WIDTH(LW), .QUEUE_DEPTH(QD)) bus ();

    predictor_port_scheduler #(
        .LOCAL_WIDTH (LW),
        .QUEUE_DEPTH (QD),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rdy, input logic lv, input logic [31:0] la,
                         input logic rv, input logic [31:0] ra, input logic rc, input logic pp);
        bus.rdy_in          = rdy;
        bus.lookup_valid    = lv;
        bus.lookup_addr     = la;
        bus.resolve_valid   = rv;
        bus.resolve_addr    = ra;
        bus.resolve_correct = rc;
        bus.pd_prediction   = pp;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.rdy, v.lv, v.la, v.rv, v.ra, v.rc, v.pp);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, ".grant"},       32'(bus.lookup_grant),   32'(v.grant));
        checkOutput({tag, ".pd_addr"},     32'(bus.pd_addr),        32'(v.pda));
        checkOutput({tag, ".pred_valid"},  32'(bus.pred_valid),     32'(v.pv));
        checkOutput({tag, ".pred_taken"},  32'(bus.pred_taken),     32'(v.pt));
        checkOutput({tag, ".transition"},  32'(bus.pd_transition),  32'(v.tr));
        checkOutput({tag, ".correctness"}, 32'(bus.pd_correctness), 32'(v.co));
        checkOutput({tag, ".ready"},       32'(bus.resolve_ready),  32'(v.rr));
        checkOutput({tag, ".count"},       32'(bus.queue_count),    32'(v.cnt));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        // rdy lv la rv ra rc pp | grant pda pv pt tr co rr cnt
        vecs[0]  = '{1, 0, 32'h0000_0000, 0, 32'h0,         0, 0, 0, 10'h000, 0, 0, 0, 0, 1, 0};
        vecs[1]  = '{1, 1, 32'h0000_0104, 0, 32'h0,         0, 1, 1, 10'h041, 0, 0, 0, 0, 1, 0};
        vecs[2]  = '{1, 0, 32'h0000_0000, 0, 32'h0,         0, 1, 0, 10'h000, 1, 1, 0, 0, 1, 0};
        vecs[3]  = '{1, 1, 32'h0000_0108, 0, 32'h0,         0, 0, 1, 10'h042, 0, 0, 0, 0, 1, 0};
        vecs[4]  = '{1, 0, 32'h0000_0000, 0, 32'h0,         0, 0, 0, 10'h000, 1, 0, 0, 0, 1, 0};
        vecs[5]  = '{1, 0, 32'h0000_0000, 1, 32'h0000_0200, 1, 0, 0, 10'h000, 0, 0, 0, 0, 1, 0};
        vecs[6]  = '{1, 0, 32'h0000_0000, 0, 32'h0,         0, 0, 0, 10'h080, 0, 0, 0, 0, 1, 1};
        vecs[7]  = '{1, 0, 32'h0000_0000, 0, 32'h0,         0, 0, 0, 10'h000, 0, 0, 1, 1, 1, 0};
        vecs[8]  = '{1, 0, 32'h0000_0000, 0, 32'h0,         0, 0, 0, 10'h000, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{1, 1, 32'h0000_0010, 1, 32'h0000_03FC, 0, 0, 1, 10'h004, 0, 0, 0, 0, 1, 0};
        vecs[10] = '{1, 1, 32'h0000_0014, 0, 32'h0,         0, 0, 1, 10'h005, 1, 0, 0, 0, 1, 1};
        vecs[11] = '{1, 0, 32'h0000_0000, 0, 32'h0,         0, 1, 0, 10'h0FF, 1, 1, 0, 0, 1, 1};
        vecs[12] = '{1, 0, 32'h0000_0000, 0, 32'h0,         0, 0, 0, 10'h000, 0, 0, 1, 0, 1, 0};
        vecs[13] = '{0, 1, 32'h0000_0020, 1, 32'h0000_0500, 1, 1, 0, 10'h008, 0, 0, 0, 0, 0, 0};

        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset.transition", 32'(bus.pd_transition),  32'd0);
        checkOutput("reset.correct",    32'(bus.pd_correctness), 32'd0);
        checkOutput("reset.pred_valid", 32'(bus.pred_valid),     32'd0);
        checkOutput("reset.count",      32'(bus.queue_count),    32'd0);
        nextCycle();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVector(i, vecs[i]);
            nextCycle();
        end

        // Starvation: one queued update, lookups held; eight grants then a forced update.
        doReset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("starve.push_count", 32'(bus.queue_count), 32'd0);
        nextCycle();
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= SL; k++) begin
            @(negedge clk);
            checkOutput($sformatf("starve.grant%0d", k), 32'(bus.lookup_grant), 32'd1);
            checkOutput($sformatf("starve.count%0d", k), 32'(bus.queue_count),  32'd1);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("starve.forced_grant", 32'(bus.lookup_grant), 32'd0);
        checkOutput("starve.forced_addr",  32'(bus.pd_addr),      32'h010);
        nextCycle();
        @(negedge clk);
        checkOutput("starve.resume_grant", 32'(bus.lookup_grant),  32'd1);
        checkOutput("starve.pulse",        32'(bus.pd_transition), 32'd1);
        checkOutput("starve.pulse_corr",   32'(bus.pd_correctness), 32'd1);
        checkOutput("starve.empty",        32'(bus.queue_count),   32'd0);
        nextCycle();

        // Full queue: four resolves under continuous lookups, then a forced update with no push.
        doReset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_1004 + 32'(4 * k), 1'(k % 2), 1'b0);
            @(negedge clk);
            checkOutput($sformatf("full.grant%0d", k), 32'(bus.lookup_grant),  32'd1);
            checkOutput($sformatf("full.count%0d", k), 32'(bus.queue_count),   32'(k));
            checkOutput($sformatf("full.ready%0d", k), 32'(bus.resolve_ready), 32'd1);
            nextCycle();
        end
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_2000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("full.count4",       32'(bus.queue_count),   32'd4);
        checkOutput("full.ready_low",    32'(bus.resolve_ready), 32'd0);
        checkOutput("full.forced_grant", 32'(bus.lookup_grant),  32'd0);
        checkOutput("full.forced_addr",  32'(bus.pd_addr),       32'h001);
        nextCycle();
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full.after_count", 32'(bus.queue_count),   32'd3);
        checkOutput("full.after_ready", 32'(bus.resolve_ready), 32'd1);
        checkOutput("full.after_grant", 32'(bus.lookup_grant),  32'd1);
        nextCycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checkOutput($sformatf("full.drain_addr%0d", j),  32'(bus.pd_addr),     32'(10'h002 + 10'(j)));
            checkOutput($sformatf("full.drain_count%0d", j), 32'(bus.queue_count), 32'(3 - j));
            if (j > 0) begin
                checkOutput($sformatf("full.drain_corr%0d", j), 32'(bus.pd_correctness), 32'(j % 2));
            end
            nextCycle();
        end
        @(negedge clk);
        checkOutput("full.drained",     32'(bus.queue_count),    32'd0);
        checkOutput("full.last_pulse",  32'(bus.pd_transition),  32'd1);
        checkOutput("full.last_corr",   32'(bus.pd_correctness), 32'd1);
        nextCycle();

        // Ready stall: the pending pulse must wait out three low cycles and fire once.
        doReset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0080, 1'b1, 1'b0);
        nextCycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall.upd_addr", 32'(bus.pd_addr), 32'h020);
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h0000_0090, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("stall.no_pulse%0d", k), 32'(bus.pd_transition), 32'd0);
            checkOutput($sformatf("stall.ready%0d", k),    32'(bus.resolve_ready), 32'd0);
            checkOutput($sformatf("stall.grant%0d", k),    32'(bus.lookup_grant),  32'd0);
            nextCycle();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall.pulse",      32'(bus.pd_transition),  32'd1);
        checkOutput("stall.pulse_corr", 32'(bus.pd_correctness), 32'd1);
        checkOutput("stall.no_push",    32'(bus.queue_count),    32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("stall.single_pulse", 32'(bus.pd_transition), 32'd0);
        nextCycle();

        // Reset while an update pulse is pending and another entry is queued.
        doReset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0084, 1'b1, 1'b0);
        nextCycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0088, 1'b0, 1'b0);
        nextCycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rstmid.pulse_before", 32'(bus.pd_transition), 32'd1);
        checkOutput("rstmid.count_before", 32'(bus.queue_count),   32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid.pulse_cleared", 32'(bus.pd_transition), 32'd0);
        checkOutput("rstmid.count_cleared", 32'(bus.queue_count),   32'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid.ready",    32'(bus.resolve_ready), 32'd1);
        checkOutput("rstmid.no_pulse", 32'(bus.pd_transition), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rstmid.dropped", 32'(bus.pd_transition), 32'd0);
        checkOutput("rstmid.empty",   32'(bus.queue_count),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
